// File: rtl/multiply_unsigned.sv
// Iterative shift-add unsigned multiplier.
// Consumes one multiplier bit per clock; the 2*WIDTH-bit product is valid
// WIDTH edges after an accepted start and is held until the next start.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, outputs cleared since reset
// BUSY  | iterating, one multiplier bit consumed per edge
// DONE  | product valid on product_hi/product_lo, start restarts
module multiply_unsigned #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic             busy,
    output logic             ready
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     sum;

    // Partial-product add for the current LSB of the multiplier; the
    // extra bit holds the carry so it survives the right shift.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
    end

    // Sequencing, operand latch and accumulate-shift datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            mcand <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand <= a;
                        acc   <= {{WIDTH{1'b0}}, b};
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= {sum, acc[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == LAST_COUNT) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags are pure decodes of the state register.
    always_comb begin
        busy       = (state == BUSY);
        ready      = (state == DONE);
        product_hi = acc[2*WIDTH-1:WIDTH];
        product_lo = acc[WIDTH-1:0];
    end

endmodule

// File: tb/tb_multiply_unsigned.sv
module tb_multiply_unsigned;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  product_hi;
    logic [W-1:0]  product_lo;
    logic          busy;
    logic          ready;

    int pass_cnt = 0;
    int total_cnt = 0;
    int overlap_seen = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] expected;
    } vec_t;

    vec_t vecs[16];

    multiply_unsigned #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .product_hi (product_hi),
        .product_lo (product_lo),
        .busy       (busy),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        return 64'(x) * 64'(y);
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Called right after an edge+1; accepts at next edge, waits for ready.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output int cycles, output int busy_cycles);
        start = 1'b1;
        a = x;
        b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cycles = 0;
        busy_cycles = 0;
        while (!ready && cycles < 200) begin
            if (busy) busy_cycles++;
            if (busy && ready) overlap_seen++;
            @(posedge clk); #1;
            a = $urandom;
            b = $urandom;
            cycles++;
        end
    endtask

    initial begin
        int cyc, bcyc;
        logic [2*W-1:0] held;

        vecs[0] = '{32'd6, 32'd7, 64'h0000_0000_0000_002A};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h1234_5678, 32'h0, 64'h0};
        vecs[3] = '{32'h0, 32'h9ABC_DEF0, 64'h0};
        vecs[4] = '{32'h1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{32'h8000_0000, 32'h2, 64'h0000_0001_0000_0000};
        for (int i = 6; i < 16; i++) begin
            vecs[i].a = (i % 3 == 0) ? ($urandom | 32'hF000_0000) : $urandom;
            vecs[i].b = (i % 2 == 0) ? ($urandom | 32'h8000_0001) : $urandom;
            vecs[i].expected = ref_mul(vecs[i].a, vecs[i].b);
        end

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_product", {product_hi, product_lo}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].a, vecs[i].b, cyc, bcyc);
            check($sformatf("vec%0d_latency", i), 64'(cyc), 64'd32);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcyc), 64'd32);
            check($sformatf("vec%0d_product", i), {product_hi, product_lo}, vecs[i].expected);
        end

        // DONE holds while start stays low
        held = {product_hi, product_lo};
        repeat (5) @(posedge clk);
        #1;
        check("done_hold_ready", 64'(ready), 64'd1);
        check("done_hold_product", {product_hi, product_lo}, held);

        // second start during BUSY is ignored, operands toggle every cycle
        start = 1'b1; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!ready && cyc < 200) begin
            if (cyc == 10) begin
                start = 1'b1; a = 32'd100; b = 32'd100;
            end else begin
                start = 1'b0; a = ~a; b = ~b;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("ignore_start_latency", 64'(cyc), 64'd32);
        check("ignore_start_product", {product_hi, product_lo}, 64'd15);

        // asynchronous reset mid-operation
        start = 1'b1; a = 32'h00FF_00FF; b = 32'hFFFF_0001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_ready", 64'(ready), 64'd0);
        check("async_reset_product", {product_hi, product_lo}, 64'd0);
        @(posedge clk); #3;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle_busy", 64'(busy), 64'd0);
        check("post_reset_idle_ready", 64'(ready), 64'd0);
        run_op(32'd9, 32'd9, cyc, bcyc);
        check("post_reset_latency", 64'(cyc), 64'd32);
        check("post_reset_product", {product_hi, product_lo}, 64'd81);

        // start held high: back-to-back results, one-cycle ready pulses
        start = 1'b1; a = 32'h0001_0000; b = 32'h0001_0000;
        @(posedge clk); #1;
        a = 32'd2; b = 32'd3;
        cyc = 0;
        while (!ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_first_latency", 64'(cyc), 64'd32);
        check("b2b_first_product", {product_hi, product_lo}, 64'h0000_0001_0000_0000);
        @(posedge clk); #1;
        check("b2b_ready_pulse", 64'(ready), 64'd0);
        check("b2b_restart_busy", 64'(busy), 64'd1);
        cyc = 1;
        while (!ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("b2b_period", 64'(cyc), 64'd33);
        check("b2b_second_product", {product_hi, product_lo}, 64'd6);
        @(posedge clk); #1;
        check("b2b_hold_after_drop", 64'(ready), 64'd1);

        check("busy_ready_overlap", 64'(overlap_seen), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time %0t, required completion earlier", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multiply_unsigned.md
Name: multiply_unsigned

Overview:
Iterative shift-add unsigned multiplier and the arithmetic counterpart of the restoring divider. Takes two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product after WIDTH iteration cycles. It processes one multiplier bit per clock. Sits beside the divider in the ALU datapath and shares its ready-style completion handshake.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request; sampled on rising edge in IDLE or DONE
a  input  WIDTH  multiplicand, latched on accepted start
b  input  WIDTH  multiplier, latched on accepted start
product_hi  output  WIDTH  upper half of a*b
product_lo  output  WIDTH  lower half of a*b
busy  output  1  high while iterating
ready  output  1  high when product is valid

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, accumulator=0, multiplicand register=0, count=0. Outputs busy=0, ready=0, product_hi=0, product_lo=0. Reset overrides everything, including mid-operation.
- State register is 2 bits: IDLE, BUSY, DONE.
- IDLE: start=1 at the edge loads the multiplicand register with a, loads acc[2W-1:0] = {W'b0, b}, clears count to 0, and goes to BUSY. start=0 stays in IDLE.
- BUSY, each edge:
  - if acc[0]=1: sum = acc[2W-1:W] + mcand as a (W+1)-bit value with carry; otherwise sum = {1'b0, acc[2W-1:W]}.
  - acc <= {sum, acc[W-1:1]}, a logical right shift that keeps the carry.
  - count <= count+1.
  - When count reaches WIDTH-1 at the edge, the next state is DONE.
- start is ignored in BUSY. Changes on a or b during BUSY have no effect because the operands are latched.
- DONE:
  - ready=1 and product = acc.
  - Product and ready hold indefinitely while start=0.
  - start=1 restarts exactly as in IDLE: ready drops at that edge and new operands are loaded.
- Latency: start accepted at edge k gives ready=1 after edge k+WIDTH (WIDTH iteration edges k+1..k+WIDTH). Throughput is one result per WIDTH+1 cycles when start is held high.
- busy=1 exactly in BUSY. ready=1 exactly in DONE. Both are never high together. Both are registered-state decodes with no combinational path from start.
- product_hi/product_lo show the raw accumulator in all states. They are only guaranteed meaningful when ready=1; the verifier checks them only under ready.
- Arithmetic: unsigned. No overflow is possible since a W×W product fits in 2W bits. The carry bit of each add must be retained in the shift.
- Counter width is clog2(WIDTH)+1 bits. It must not wrap before the transition to DONE.
- Zero operands need no special-casing: the result is 0 after full latency, with no early termination.

Test Plan:
- Reset released, a=6, b=7, start pulse → ready after 32 cycles; product_hi=0x00000000, product_lo=0x0000002A; busy high for exactly 32 cycles.
- a=0xFFFFFFFF, b=0xFFFFFFFF → product_hi=0xFFFFFFFE, product_lo=0x00000001 (exercises the carry on every add).
- a=0x12345678, b=0, and separately a=0, b=0x9ABCDEF0 → product=0 in both cases, same 32-cycle latency.
- Start at cycle 0 with a=3, b=5. Pulse start again at cycle 10 with a=100, b=100, and toggle a/b every cycle → second start ignored; result 15 at cycle 32.
- Drive reset=0 asynchronously at cycle 15 of a multiply → busy, ready and product go to 0 immediately without waiting for a clock edge. After release the block is in IDLE; a new start (a=9, b=9) yields 81.
- Hold start=1 continuously with a=0x10000, b=0x10000, then a=2, b=3 → ready pulses for one cycle per result. Results are 0x00000001_00000000 then 6. Feed both products and b back into divide_unsigned; the quotient must equal a and the remainder 0.
